// File: rtl/if_id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// if_id_hazard_ctrl
// Pipeline sequencer for the 8-bit in-order core. It decides, every cycle,
// whether the PC and the IF/ID register may advance, whether IF/ID is zeroed,
// and whether a NOP is loaded into ID/EX. It resolves three hazards:
// load-use stalls, taken-branch flushes and multicycle-multiply waits.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-low reset
//   id_rs1/id_rs2  ID-stage source registers, id_use_rs1/2 qualify them
//   ex_rd          EX-stage destination register, ex_is_load marks a load
//   branch_taken   EX resolved a taken branch (pulse)
//   mul_start      EX issued a multicycle multiply (pulse)
//   mul_done       multiplier result valid (pulse)
//   pc_write_en    PC may advance
//   if_id_write_en IF/ID may load a new instruction
//   ID_flush       zero IF/ID on the next edge
//   id_ex_bubble   load a NOP into ID/EX on the next edge
//   mul_timeout    sticky flag: a multiply wait ended by timeout
//   stall_count    saturating count of stall/flush cycles
// ---------------------------------------------------------------------------
module if_id_hazard_ctrl #(
   parameter int REG_AW       = 3,
   parameter int FLUSH_CYCLES = 1,
   parameter int MUL_TIMEOUT  = 15,
   parameter int CNT_W        = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic              branch_taken,
   input  logic              mul_start,
   input  logic              mul_done,
   output logic              pc_write_en,
   output logic              if_id_write_en,
   output logic              ID_flush,
   output logic              id_ex_bubble,
   output logic              mul_timeout,
   output logic [CNT_W-1:0]  stall_count
);

   typedef enum logic [1:0] {RUN, FLUSH, MUL_WAIT} state_t;

   state_t     state, state_nxt;
   logic [2:0] flush_cnt, flush_cnt_nxt;
   logic [7:0] mul_cnt, mul_cnt_nxt;
   logic       timeout_set;
   logic       load_use;
   logic       pc_en_run, flush_run;

   // Register 0 is an ordinary register here, so rd==0 still counts as a hit.
   assign load_use = ex_is_load &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      pc_en_run     = 1'b1;
      flush_run     = 1'b0;
      id_ex_bubble  = 1'b0;
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      mul_cnt_nxt   = mul_cnt;
      timeout_set   = 1'b0;

      case (state)
         RUN: begin
            if (branch_taken) begin
               // PC loads the branch target, so the enables stay high.
               flush_run    = 1'b1;
               id_ex_bubble = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt     = FLUSH;
                  flush_cnt_nxt = 3'(FLUSH_CYCLES - 1);
               end
            end else if (mul_start) begin
               pc_en_run    = 1'b0;
               id_ex_bubble = 1'b1;
               mul_cnt_nxt  = '0;
               // A same-cycle done means the result is already available.
               if (!mul_done) state_nxt = MUL_WAIT;
            end else if (load_use) begin
               // The load leaves EX next cycle, so one stall cycle suffices.
               pc_en_run    = 1'b0;
               id_ex_bubble = 1'b1;
            end
         end
         FLUSH: begin
            // The flushed path cannot branch; branch_taken is ignored here.
            flush_run     = 1'b1;
            id_ex_bubble  = 1'b1;
            flush_cnt_nxt = flush_cnt - 3'd1;
            if (flush_cnt == 3'd1) state_nxt = RUN;
         end
         MUL_WAIT: begin
            pc_en_run    = 1'b0;
            id_ex_bubble = 1'b1;
            mul_cnt_nxt  = mul_cnt + 8'd1;
            if (mul_done) begin
               state_nxt = RUN;
            end else if (mul_cnt == 8'(MUL_TIMEOUT - 1)) begin
               state_nxt   = RUN;
               timeout_set = 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase

      pc_write_en    = pc_en_run;
      if_id_write_en = pc_en_run;
      ID_flush       = flush_run;

      // Hold the front end quiet and drain ID/EX while reset is asserted.
      if (!reset) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         ID_flush       = 1'b1;
         id_ex_bubble   = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= RUN;
         flush_cnt   <= '0;
         mul_cnt     <= '0;
         stall_count <= '0;
         mul_timeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         mul_cnt   <= mul_cnt_nxt;
         if (timeout_set) mul_timeout <= 1'b1;
         // Use the pre-reset-override values: reset cycles are not counted.
         if ((!pc_en_run || flush_run) && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule
